// File: rtl/bb_phase_detector.sv
// Bang-bang phase detector: votes early/late from data/edge samples and issues
// single-cycle inc/dec corrections to a phase rotator, with holdoff and lock detect.
module bb_phase_detector #(
   parameter int THRESH   = 4,
   parameter int HOLDOFF  = 8,
   parameter int LOCK_WIN = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic samp_valid,
   input  logic samp_data,
   input  logic samp_edge,
   output logic inc,
   output logic dec,
   output logic lock
);

   // state | meaning
   // PRIME | waiting for the first valid sample to seed d_prev
   // TRACK | accumulating up/down votes toward +/-THRESH
   // HOLD  | correction just issued; votes discarded for HOLDOFF cycles
   typedef enum logic [1:0] {PRIME, TRACK, HOLD} state_t;

   localparam int AW = $clog2(THRESH + 1) + 1;
   localparam int LW = $clog2(LOCK_WIN + 1);

   localparam logic signed [AW-1:0] ACC_ONE = AW'(1);
   localparam logic signed [AW-1:0] THR_POS = AW'(THRESH);
   localparam logic signed [AW-1:0] THR_NEG = AW'(-THRESH);
   localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_WIN);
   localparam logic [7:0]           HOLD_LOAD = 8'(HOLDOFF);

   state_t                 state;
   logic                   d_prev;
   logic signed [AW-1:0]   acc;
   logic [7:0]             hold_cnt;
   logic [LW-1:0]          lock_cnt;

   logic                   transition;
   logic                   up_vote;
   logic                   dn_vote;
   logic signed [AW-1:0]   acc_upd;
   logic [LW-1:0]          lock_next;

   // A transition whose edge sample still matches the old bit means the clock is early.
   assign transition = samp_data ^ d_prev;
   assign up_vote    = transition & (samp_edge == d_prev);
   assign dn_vote    = transition & (samp_edge == samp_data);

   always_comb begin
      acc_upd = acc;
      if (up_vote)
         acc_upd = acc + ACC_ONE;
      else if (dn_vote)
         acc_upd = acc - ACC_ONE;
   end

   assign lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= PRIME;
         d_prev   <= 1'b0;
         acc      <= '0;
         hold_cnt <= '0;
         lock_cnt <= '0;
         inc      <= 1'b0;
         dec      <= 1'b0;
         lock     <= 1'b0;
      end else begin
         inc <= 1'b0;
         dec <= 1'b0;
         case (state)
            PRIME: begin
               if (samp_valid) begin
                  d_prev <= samp_data;
                  state  <= TRACK;
               end
            end
            TRACK: begin
               if (samp_valid) begin
                  d_prev <= samp_data;
                  if ((acc_upd == THR_POS) || (acc_upd == THR_NEG)) begin
                     acc      <= '0;
                     inc      <= (acc_upd == THR_POS);
                     dec      <= (acc_upd == THR_NEG);
                     hold_cnt <= HOLD_LOAD;
                     lock_cnt <= '0;
                     lock     <= 1'b0;
                     state    <= HOLD;
                  end else begin
                     acc      <= acc_upd;
                     lock_cnt <= lock_next;
                     lock     <= (lock_next == LOCK_MAX);
                  end
               end
            end
            HOLD: begin
               // Counter runs every clk regardless of samp_valid.
               hold_cnt <= hold_cnt - 8'd1;
               if (hold_cnt == 8'd1)
                  state <= TRACK;
               if (samp_valid) begin
                  d_prev   <= samp_data;
                  lock_cnt <= lock_next;
                  lock     <= (lock_next == LOCK_MAX);
               end
            end
            default: state <= PRIME;
         endcase
      end
   end

endmodule

// File: tb/tb_bb_phase_detector.sv
// Directed bench for bb_phase_detector: a sample-level reference model checked
// every cycle, plus literal expectations for the key timing scenarios.
module tb_bb_phase_detector;

   localparam int THRESH   = 4;
   localparam int HOLDOFF  = 8;
   localparam int LOCK_WIN = 64;

   logic clk = 1'b0;
   logic rst;
   logic samp_valid;
   logic samp_data;
   logic samp_edge;
   logic inc;
   logic dec;
   logic lock;

   int n_vec = 0;
   int n_err = 0;
   logic cur;

   // reference model state
   bit   primed;
   bit   m_dprev;
   int   m_acc;
   int   m_hold;
   int   m_lcnt;
   bit   m_inc;
   bit   m_dec;
   bit   m_lock;

   bb_phase_detector #(
      .THRESH   (THRESH),
      .HOLDOFF  (HOLDOFF),
      .LOCK_WIN (LOCK_WIN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .samp_valid (samp_valid),
      .samp_data  (samp_data),
      .samp_edge  (samp_edge),
      .inc        (inc),
      .dec        (dec),
      .lock       (lock)
   );

   always #5 clk = ~clk;

   // Model: m_hold counts remaining holdoff cycles; votes only matter when it is 0.
   initial begin
      int  vote;
      bit  in_hold;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            primed = 0; m_dprev = 0; m_acc = 0; m_hold = 0; m_lcnt = 0;
            m_inc = 0; m_dec = 0; m_lock = 0;
         end else begin
            m_inc   = 0;
            m_dec   = 0;
            in_hold = (m_hold > 0);
            if (in_hold) m_hold = m_hold - 1;
            if (samp_valid) begin
               if (!primed) begin
                  primed  = 1;
               end else begin
                  if (samp_data == m_dprev) vote = 0;
                  else if (samp_edge == m_dprev) vote = 1;
                  else vote = -1;
                  if (!in_hold) m_acc = m_acc + vote;
                  if (!in_hold && (m_acc == THRESH || m_acc == -THRESH)) begin
                     m_inc  = (m_acc == THRESH);
                     m_dec  = (m_acc == -THRESH);
                     m_acc  = 0;
                     m_hold = HOLDOFF;
                     m_lcnt = 0;
                  end else if (m_lcnt < LOCK_WIN) begin
                     m_lcnt = m_lcnt + 1;
                  end
               end
               m_dprev = samp_data;
            end
            m_lock = (m_lcnt == LOCK_WIN);
         end
      end
   end

   function automatic void chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic cmp_all();
      chk("inc", int'(inc), int'(m_inc));
      chk("dec", int'(dec), int'(m_dec));
      chk("lock", int'(lock), int'(m_lock));
      chk("inc_dec_exclusive", int'(inc & dec), 0);
   endtask

   task automatic step(input logic v, input logic d, input logic e);
      samp_valid = v;
      samp_data  = d;
      samp_edge  = e;
      @(negedge clk);
      cmp_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      samp_valid = 1'b0;
      @(negedge clk);
      cmp_all();
      rst = 1'b1;
   endtask

   task automatic up_vote();
      step(1'b1, ~cur, cur);
      cur = ~cur;
   endtask

   task automatic dn_vote();
      step(1'b1, ~cur, ~cur);
      cur = ~cur;
   endtask

   task automatic gap3();
      repeat (3) step(1'b0, 1'($urandom), 1'($urandom));
   endtask

   initial begin
      logic d;
      rst = 1'b0; samp_valid = 1'b0; samp_data = 1'b0; samp_edge = 1'b0; cur = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_inc", int'(inc), 0);
      chk("reset_dec", int'(dec), 0);
      chk("reset_lock", int'(lock), 0);
      rst = 1'b1;

      // constant data: lock after 1 prime + 64 counted samples
      for (int i = 1; i <= 65; i++) begin
         step(1'b1, 1'b1, 1'b1);
         if (i == 64) chk("const_lock_at_64", int'(lock), 0);
         if (i == 65) chk("const_lock_at_65", int'(lock), 1);
      end
      chk("const_model_lock", int'(m_lock), 1);

      // alternating data, edge == previous bit -> inc at samples 5 and 17
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         d = 1'((i - 1) & 1);
         step(1'b1, d, ~d);
         chk($sformatf("alt_up_inc_%0d", i), int'(inc), (i == 5 || i == 17) ? 1 : 0);
         if (i == 5) chk("alt_up_model_inc", int'(m_inc), 1);
      end

      // alternating data, edge == current bit -> dec at samples 5 and 17
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         d = 1'((i - 1) & 1);
         step(1'b1, d, d);
         chk($sformatf("alt_dn_dec_%0d", i), int'(dec), (i == 5 || i == 17) ? 1 : 0);
         chk($sformatf("alt_dn_inc_%0d", i), int'(inc), 0);
      end

      // up,down,up,up,up -> acc 1,0,1,2,3; one more up -> inc
      do_reset();
      step(1'b1, 1'b0, 1'b0); cur = 1'b0;
      up_vote(); chk("mix_acc1", m_acc, 1); chk("mix_inc1", int'(inc), 0);
      dn_vote(); chk("mix_acc2", m_acc, 0); chk("mix_dec2", int'(dec), 0);
      up_vote(); chk("mix_acc3", m_acc, 1);
      up_vote(); chk("mix_acc4", m_acc, 2);
      up_vote(); chk("mix_acc5", m_acc, 3); chk("mix_inc5", int'(inc), 0);
      up_vote(); chk("mix_acc6", m_acc, 0); chk("mix_inc6", int'(inc), 1);
      step(1'b1, cur, cur); chk("mix_inc_single", int'(inc), 0);

      // up votes separated by invalid gaps
      do_reset();
      step(1'b1, 1'b0, 1'b0); cur = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         up_vote();
         chk($sformatf("gap_inc_%0d", k), int'(inc), (k == 4) ? 1 : 0);
         gap3();
         chk($sformatf("gap_acc_%0d", k), m_acc, (k == 4) ? 0 : k);
      end

      // reset mid-stream with acc=3 and lock=1
      do_reset();
      for (int i = 1; i <= 65; i++) step(1'b1, 1'b1, 1'b1);
      cur = 1'b1;
      repeat (3) up_vote();
      chk("rmid_acc3", m_acc, 3);
      chk("rmid_lock_before", int'(lock), 1);
      #2 rst = 1'b0;
      #1;
      chk("rmid_async_inc", int'(inc), 0);
      chk("rmid_async_dec", int'(dec), 0);
      chk("rmid_async_lock", int'(lock), 0);
      samp_valid = 1'b0;
      @(negedge clk);
      cmp_all();
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b0); cur = 1'b0;
      chk("rmid_prime_inc", int'(inc), 0);
      for (int k = 1; k <= 4; k++) begin
         up_vote();
         chk($sformatf("rmid_inc_%0d", k), int'(inc), (k == 4) ? 1 : 0);
      end
      step(1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bb_phase_detector.md
BB_PHASE_DETECTOR -- requirements
Module: bb_phase_detector

Interface
REQ-001 SHALL have parameter THRESH, default 4: net vote count (2..15) that triggers one correction pulse.
REQ-002 SHALL have parameter HOLDOFF, default 8: clock cycles (1..255) during which votes are ignored after a correction.
REQ-003 SHALL have parameter LOCK_WIN, default 64: correction-free counted samples (1..1023) needed to assert lock.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port samp_valid  input  1  qualifies samp_data/samp_edge this cycle.
REQ-007 SHALL have port samp_data  input  1  data-centre sample (early/late-clock domain already retimed to clk).
REQ-008 SHALL have port samp_edge  input  1  edge sample taken between previous and current data samples.
REQ-009 SHALL have port inc  output  1  single-cycle request to the phase rotator to advance phase.
REQ-010 SHALL have port dec  output  1  single-cycle request to the phase rotator to retard phase.
REQ-011 SHALL have port lock  output  1  high when loop is considered settled.

Function
REQ-012 SHALL implement FSM states PRIME, TRACK, HOLD.
REQ-013 SHALL, in PRIME, on first valid sample store samp_data as d_prev and go to TRACK; no vote, no lock counting.
REQ-014 SHALL ignore all inputs in a cycle with samp_valid=0: d_prev, accumulator, lock counter unchanged (hold counter still decrements).
REQ-015 SHALL, on every valid sample in TRACK or HOLD, update d_prev <= samp_data.
REQ-016 SHALL classify a valid sample: no transition (samp_data==d_prev) -> no vote; transition and samp_edge==d_prev -> up vote; transition and samp_edge==samp_data -> down vote.
REQ-017 SHALL, in TRACK, add +1 per up vote and -1 per down vote to a signed accumulator wide enough for +/-THRESH without overflow.
REQ-018 SHALL, when the updated accumulator equals +THRESH, clear it to 0, assert inc in the next cycle for exactly one cycle, load hold counter with HOLDOFF, enter HOLD.
REQ-019 SHALL, when the updated accumulator equals -THRESH, do likewise with dec.
REQ-020 SHALL never assert inc and dec in the same cycle.
REQ-021 SHALL, in HOLD, discard votes (accumulator held at 0), decrement hold counter every clk, return to TRACK when it reaches 0; HOLD thus lasts exactly HOLDOFF cycles starting the cycle inc/dec is high.
REQ-022 SHALL count valid samples in TRACK and HOLD in a lock counter saturating at LOCK_WIN.
REQ-023 SHALL drive lock=1 exactly when the lock counter equals LOCK_WIN, registered.
REQ-024 SHALL clear the lock counter and lock in the same cycle inc or dec is asserted.

Reset
REQ-025 SHALL, while rst=0, asynchronously force inc=0, dec=0, lock=0, accumulator=0, hold counter=0, lock counter=0, d_prev=0, state=PRIME.
REQ-026 SHALL, on rst deassertion mid-stream, restart at PRIME; any partially accumulated votes are lost and no pulse is emitted.

Verification
REQ-027 SHALL pass: constant samp_data=1, samp_valid=1 every cycle -> inc=dec=0 throughout; lock rises after the 65th valid sample (1 prime + 64).
REQ-028 SHALL pass: alternating data 0,1,0,1..., samp_edge==d_prev -> inc high one cycle after the 5th valid sample, low next cycle; no further inc for 8 cycles; next inc 4 transitions after HOLD ends.
REQ-029 SHALL pass: alternating data with samp_edge==samp_data -> identical timing on dec; inc stays 0.
REQ-030 SHALL pass: vote sequence up,down,up,up,up -> accumulator 1,0,1,2,3, no pulse; one further up vote -> single inc pulse, accumulator 0.
REQ-031 SHALL pass: up votes interleaved with samp_valid=0 gaps of 3 cycles -> accumulator unchanged across gaps; inc after 4th up vote regardless of gaps.
REQ-032 SHALL pass: rst pulled low while accumulator=3 and lock=1 -> inc, dec, lock 0 immediately (no clk edge); after release, 4 more up votes plus 1 prime sample needed before inc.
